ram8_copy_master: RTL



---
 rtl/ram8_copy_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram8_copy_master.sv
// FILL/COPY command engine driving the 8-bit address / 8-bit data fake-RAM port.
// Optional build macro RAM8_COPY_MASTER_CSUM_EN adds ACsum, an XOR of every written word.
module ram8_copy_master #(
    parameter int unsigned CAddrLen = 8,
    parameter int unsigned CDataLen = 8,
    parameter int unsigned CRdLat   = 1
) (
    input  logic                AClkH,
    input  logic                AResetHN,
    input  logic                AClkHEn,
    input  logic                ACmdStart,
    input  logic                ACmdOp,
    input  logic [CAddrLen-1:0] ACmdSrc,
    input  logic [CAddrLen-1:0] ACmdDst,
    input  logic [CAddrLen-1:0] ACmdLen,
    input  logic [CDataLen-1:0] ACmdData,
    output logic                ABusy,
    output logic                ADone,
    output logic [CAddrLen-1:0] AAddrWr,
    output logic [CAddrLen-1:0] AAddrRd,
    output logic [CDataLen-1:0] AMosi,
    input  logic [CDataLen-1:0] AMiso,
`ifdef RAM8_COPY_MASTER_CSUM_EN
    output logic [CDataLen-1:0] ACsum,
`endif
    output logic                AWrEn
);

    localparam int unsigned CWaitW = 2;
    localparam logic        OP_FILL = 1'b0;
    localparam logic        OP_COPY = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t              state, state_d;
    logic                op_q, op_d;
    logic [CAddrLen-1:0] src_q, src_d;
    logic [CAddrLen-1:0] dst_q, dst_d;
    logic [CAddrLen-1:0] cnt_q, cnt_d;
    logic [CDataLen-1:0] fill_q, fill_d;
    logic [CWaitW-1:0]   wait_q, wait_d;

    logic                busy_d;
    logic                done_d;
    logic                wren_d;
    logic [CAddrLen-1:0] addr_wr_d;
    logic [CAddrLen-1:0] addr_rd_d;
    logic [CDataLen-1:0] mosi_d;
    logic                accept;

`ifdef RAM8_COPY_MASTER_CSUM_EN
    logic [CDataLen-1:0] csum_d;
`endif

    assign accept = (state == IDLE) && ACmdStart;

    // Next state, working registers and registered port values
    always_comb begin
        state_d   = state;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        wait_d    = wait_q;
        addr_wr_d = AAddrWr;
        addr_rd_d = AAddrRd;
        mosi_d    = AMosi;

        unique case (state)
            IDLE: begin
                if (ACmdStart) begin
                    op_d   = ACmdOp;
                    src_d  = ACmdSrc;
                    dst_d  = ACmdDst;
                    cnt_d  = ACmdLen;
                    fill_d = ACmdData;
                    if (ACmdLen == '0) begin
                        state_d = FIN;
                    end else if (ACmdOp == OP_COPY) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD: begin
                state_d = WAIT;
                wait_d  = CWaitW'(CRdLat - 1);
            end
            WAIT: begin
                // Read data is valid at the end of the last wait cycle
                if (wait_q == '0) begin
                    state_d = WR;
                    mosi_d  = AMiso;
                end else begin
                    wait_d = wait_q - CWaitW'(1);
                end
            end
            WR: begin
                src_d = src_q + CAddrLen'(1);
                dst_d = dst_q + CAddrLen'(1);
                cnt_d = cnt_q - CAddrLen'(1);
                if (cnt_q == CAddrLen'(1)) begin
                    state_d = FIN;
                end else if (op_q == OP_COPY) begin
                    state_d = RD;
                end else begin
                    state_d = WR;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Port values follow the state being entered so they line up with it
        if (state_d == RD) begin
            addr_rd_d = src_d;
        end
        if (state_d == WR) begin
            addr_wr_d = dst_d;
            if (op_d == OP_FILL) begin
                mosi_d = fill_d;
            end
        end

        wren_d = (state_d == WR);
        busy_d = (state_d == RD) || (state_d == WAIT) || (state_d == WR);
        done_d = (state_d == FIN);
    end

`ifdef RAM8_COPY_MASTER_CSUM_EN
    // Running XOR of the word on AMosi during each write cycle
    always_comb begin
        csum_d = ACsum;
        if (accept) begin
            csum_d = '0;
        end else if (state == WR) begin
            csum_d = ACsum ^ AMosi;
        end
    end
`endif

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            state   <= IDLE;
            op_q    <= OP_FILL;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            wait_q  <= '0;
            ABusy   <= 1'b0;
            ADone   <= 1'b0;
            AWrEn   <= 1'b0;
            AAddrWr <= '0;
            AAddrRd <= '0;
            AMosi   <= '0;
`ifdef RAM8_COPY_MASTER_CSUM_EN
            ACsum   <= '0;
`endif
        end else if (AClkHEn) begin
            state   <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            wait_q  <= wait_d;
            ABusy   <= busy_d;
            ADone   <= done_d;
            AWrEn   <= wren_d;
            AAddrWr <= addr_wr_d;
            AAddrRd <= addr_rd_d;
            AMosi   <= mosi_d;
`ifdef RAM8_COPY_MASTER_CSUM_EN
            ACsum   <= csum_d;
`endif
        end
    end

endmodule
